// File: rtl/wb_queue_if.sv
// Writeback queue bus: ALU/MEM request ports, register-file write port, pending-write query.
interface wb_queue_if;
   logic       alu_valid;
   logic [1:0] alu_rd;
   logic [7:0] alu_data;
   logic       alu_ready;
   logic       mem_valid;
   logic [1:0] mem_rd;
   logic [7:0] mem_data;
   logic       mem_ready;
   logic       wenabel;
   logic [1:0] rd;
   logic [7:0] write_data;
   logic [1:0] chk_reg;
   logic       pend_hit;
   logic [7:0] pend_data;

   modport master (
      output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, chk_reg,
      input  alu_ready, mem_ready, wenabel, rd, write_data, pend_hit, pend_data
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, chk_reg,
      output alu_ready, mem_ready, wenabel, rd, write_data, pend_hit, pend_data
   );
endinterface

// File: rtl/wb_queue.sv
// 4-entry writeback FIFO merging ALU and MEM results into one register-file write port.
// Optional pending-write lookup enabled by defining WB_BYPASS_EN.
module wb_queue (
   input  logic        clk,
   input  logic        rst,
   wb_queue_if.slave   bus
);
   typedef struct packed {
      logic [1:0] rd;
      logic [7:0] data;
   } entry_t;

   entry_t     fifo_q [4];
   logic [2:0] count_q, count_d;
   logic [1:0] head_q, head_d;
   logic [1:0] tail_q, tail_d;
   logic [1:0] mem_slot;
   logic       wenabel_q;
   logic [1:0] rd_q;
   logic [7:0] wdata_q;
   logic       alu_push, mem_push, pop;

   // Readiness looks only at the registered count; a same-cycle pop earns no credit.
   assign bus.alu_ready = (count_q < 3'd4);
   assign bus.mem_ready = (count_q < 3'd3) || ((count_q == 3'd3) && !bus.alu_valid);

   assign alu_push = bus.alu_valid && bus.alu_ready;
   assign mem_push = bus.mem_valid && bus.mem_ready;
   assign pop      = (count_q != 3'd0);

   // ALU lands first (older); MEM takes the following slot.
   assign mem_slot = tail_q + 2'(alu_push);
   assign count_d  = count_q + 3'(alu_push) + 3'(mem_push) - 3'(pop);
   assign head_d   = head_q + 2'(pop);
   assign tail_d   = tail_q + 2'(alu_push) + 2'(mem_push);

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         wenabel_q <= 1'b0;
         rd_q      <= '0;
         wdata_q   <= '0;
         for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      end else begin
         count_q   <= count_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         wenabel_q <= pop;
         if (alu_push) fifo_q[tail_q]   <= '{rd: bus.alu_rd, data: bus.alu_data};
         if (mem_push) fifo_q[mem_slot] <= '{rd: bus.mem_rd, data: bus.mem_data};
         if (pop) begin
            rd_q    <= fifo_q[head_q].rd;
            wdata_q <= fifo_q[head_q].data;
         end
      end
   end

   assign bus.wenabel    = wenabel_q;
   assign bus.rd         = rd_q;
   assign bus.write_data = wdata_q;

`ifdef WB_BYPASS_EN
   // Scan oldest to youngest so the last match (nearest the tail) wins.
   always_comb begin
      logic [1:0] idx;
      bus.pend_hit  = 1'b0;
      bus.pend_data = '0;
      idx           = '0;
      if (wenabel_q && (rd_q == bus.chk_reg)) begin
         bus.pend_hit  = 1'b1;
         bus.pend_data = wdata_q;
      end
      for (int i = 0; i < 4; i++) begin
         idx = head_q + 2'(i);
         if ((3'(i) < count_q) && (fifo_q[idx].rd == bus.chk_reg)) begin
            bus.pend_hit  = 1'b1;
            bus.pend_data = fifo_q[idx].data;
         end
      end
   end
`else
   logic unused_chk;
   assign unused_chk    = ^bus.chk_reg;
   assign bus.pend_hit  = 1'b0;
   assign bus.pend_data = '0;
`endif
endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed scenarios plus random traffic against a queue-based reference.
// Bypass checks are active when WB_BYPASS_EN is defined.
module tb_wb_queue;
   logic clk = 1'b0;
   logic rst;
   wb_queue_if bus ();

   wb_queue dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] rd;
      logic [7:0] data;
   } ent_t;

   ent_t       mq[$];
   logic       m_wen;
   logic [1:0] m_rd;
   logic [7:0] m_data;
   int         tests  = 0;
   int         failed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      logic       eh;
      logic [7:0] ed;
      check({tag, "_wen"},  32'(bus.wenabel),    32'(m_wen));
      check({tag, "_rd"},   32'(bus.rd),         32'(m_rd));
      check({tag, "_data"}, 32'(bus.write_data), 32'(m_data));
      eh = 1'b0;
      ed = '0;
`ifdef WB_BYPASS_EN
      if (m_wen && m_rd == bus.chk_reg) begin eh = 1'b1; ed = m_data; end
      foreach (mq[i]) if (mq[i].rd == bus.chk_reg) begin eh = 1'b1; ed = mq[i].data; end
`endif
      check({tag, "_phit"},  32'(bus.pend_hit),  32'(eh));
      check({tag, "_pdata"}, 32'(bus.pend_data), 32'(ed));
   endtask

   task automatic step(input string tag, input bit av, input logic [1:0] ard, input logic [7:0] ad,
                       input bit mv, input logic [1:0] mrd, input logic [7:0] md,
                       input logic [1:0] chk);
      bit ear, emr;
      ent_t e;
      @(negedge clk);
      bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
      bus.mem_valid = mv; bus.mem_rd = mrd; bus.mem_data = md;
      bus.chk_reg   = chk;
      #1;
      ear = (mq.size() < 4);
      emr = (mq.size() < 3) || (mq.size() == 3 && !av);
      check({tag, "_alu_ready"}, 32'(bus.alu_ready), 32'(ear));
      check({tag, "_mem_ready"}, 32'(bus.mem_ready), 32'(emr));
      @(posedge clk);
      if (mq.size() > 0) begin
         e = mq.pop_front();
         m_wen = 1'b1; m_rd = e.rd; m_data = e.data;
      end else m_wen = 1'b0;
      if (av && ear) mq.push_back('{ard, ad});
      if (mv && emr) mq.push_back('{mrd, md});
      #1;
      check_outputs(tag);
   endtask

   task automatic idle(input string tag, input logic [1:0] chk);
      step(tag, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, chk);
   endtask

   task automatic rst_step(input string tag);
      @(negedge clk);
      rst = 1'b1;
      bus.alu_valid = 1'($urandom_range(0, 1)); bus.alu_rd = 2'($urandom); bus.alu_data = 8'($urandom);
      bus.mem_valid = 1'($urandom_range(0, 1)); bus.mem_rd = 2'($urandom); bus.mem_data = 8'($urandom);
      @(posedge clk);
      mq.delete();
      m_wen = 1'b0; m_rd = '0; m_data = '0;
      #1;
      check_outputs(tag);
      @(negedge clk);
      rst = 1'b0;
      bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
      #1;
      check({tag, "_alu_ready_after"}, 32'(bus.alu_ready), 32'd1);
      check({tag, "_mem_ready_after"}, 32'(bus.mem_ready), 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
      bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
      bus.chk_reg = '0;
      m_wen = 1'b0; m_rd = '0; m_data = '0;
      repeat (2) @(posedge clk);
      rst_step("reset");

      // Single ALU write: visible one edge after acceptance, gone the edge after.
      step("r035_e0", 1'b1, 2'd0, 8'hAA, 1'b0, 2'd0, 8'h00, 2'd0);
      check("r035_e0_wen", 32'(bus.wenabel), 32'd0);
      idle("r035_e1", 2'd0);
      check("r035_e1_wen", 32'(bus.wenabel), 32'd1);
      check("r035_e1_rd", 32'(bus.rd), 32'd0);
      check("r035_e1_data", 32'(bus.write_data), 32'hAA);
      idle("r035_e2", 2'd0);
      check("r035_e2_wen", 32'(bus.wenabel), 32'd0);
      check("r035_e2_hold", 32'(bus.write_data), 32'hAA);

      // Simultaneous ALU and MEM: ALU drains first.
      step("r036_push", 1'b1, 2'd1, 8'h11, 1'b1, 2'd2, 8'h22, 2'd0);
      idle("r036_w1", 2'd0);
      check("r036_w1_rd", 32'(bus.rd), 32'd1);
      check("r036_w1_data", 32'(bus.write_data), 32'h11);
      idle("r036_w2", 2'd0);
      check("r036_w2_wen", 32'(bus.wenabel), 32'd1);
      check("r036_w2_rd", 32'(bus.rd), 32'd2);
      check("r036_w2_data", 32'(bus.write_data), 32'h22);
      idle("r036_w3", 2'd0);

      // Build occupancy to 3, then offer both sources.
      step("r038_a", 1'b1, 2'd0, 8'h01, 1'b1, 2'd1, 8'h02, 2'd0);
      step("r038_b", 1'b1, 2'd2, 8'h03, 1'b1, 2'd3, 8'h04, 2'd0);
      check("r038_depth", 32'(mq.size()), 32'd3);
      step("r038_c", 1'b1, 2'd1, 8'h05, 1'b1, 2'd2, 8'h06, 2'd0);
      check("r038_alu_ready", 32'(bus.alu_ready), 32'd1);
      check("r038_mem_ready", 32'(bus.mem_ready), 32'd0);

      // Reset with entries queued: nothing further is written.
      rst_step("r042_rst");
      for (int i = 0; i < 4; i++) begin
         idle("r042_idle", 2'd0);
         check("r042_no_write", 32'(bus.wenabel), 32'd0);
      end

`ifdef WB_BYPASS_EN
      step("r040_push", 1'b1, 2'd3, 8'h10, 1'b1, 2'd3, 8'h20, 2'd3);
      check("r040_hit", 32'(bus.pend_hit), 32'd1);
      check("r040_data", 32'(bus.pend_data), 32'h20);
      @(negedge clk);
      bus.alu_valid = 1'b0; bus.mem_valid = 1'b0; bus.chk_reg = 2'd1;
      #1;
      check("r041_hit", 32'(bus.pend_hit), 32'd0);
      check("r041_data", 32'(bus.pend_data), 32'd0);
      idle("r040_drain1", 2'd3);
      check("r040_drain1_data", 32'(bus.pend_data), 32'h20);
      idle("r040_drain2", 2'd3);
      idle("r040_drain3", 2'd3);
`endif

      // Random traffic with sources holding requests that were refused.
      begin
         bit av = 0, mv = 0;
         logic [1:0] ard = '0, mrd = '0;
         logic [7:0] ad = '0, md = '0;
         for (int n = 0; n < 400; n++) begin
            bit ar, mr;
            if ($urandom_range(0, 39) == 0) begin
               rst_step("rand_rst");
               av = 0; mv = 0;
            end else begin
               if (!av && $urandom_range(0, 3) != 0) begin av = 1; ard = 2'($urandom); ad = 8'($urandom); end
               if (!mv && $urandom_range(0, 3) != 0) begin mv = 1; mrd = 2'($urandom); md = 8'($urandom); end
               ar = (mq.size() < 4);
               mr = (mq.size() < 3) || (mq.size() == 3 && !av);
               step("rand", av, ard, ad, mv, mrd, md, 2'($urandom));
               if (av && ar) av = 0;
               if (mv && mr) mv = 0;
            end
         end
      end
      for (int i = 0; i < 5; i++) idle("flush", 2'($urandom));
      check("flush_empty_wen", 32'(bus.wenabel), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
